pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
Playback controller for the memory game's pattern store. On a start request it walks a stored sequence of 2-bit symbols through a synchronous-read pattern memory and drives one-hot LED flashes with programmable on/off timing. It signals completion so the game FSM can hand over to player input. It replaces ad-hoc show/off sequencing inside the game FSM with one reusable, self-timed block.

Parameters:
ON_TICKS, 12500000, clock cycles an LED is lit per step (>=1)
OFF_TICKS, 12500000, clock cycles of dark gap before each step (>=2, covers memory read latency)
MAX_LEN, 16, maximum sequence length; ADDR_W = $clog2(MAX_LEN) derived locally
SPEED_STEP, 500000, on-time reduction per extra step (only with SEQ_SPEEDUP_EN)
MIN_TICKS, 2500000, on-time floor (only with SEQ_SPEEDUP_EN)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
i_start  in  1  start playback; sampled only in IDLE
i_len  in  ADDR_W+1  number of steps to show, valid range 1..MAX_LEN, sampled with i_start
i_abort  in  1  cancel playback
o_pat_addr  out  ADDR_W  pattern memory read address (= current step index)
i_pat_data  in  2  pattern memory read data, valid 1 cycle after o_pat_addr changes
o_led  out  4  one-hot flash output, 0 when dark
o_busy  out  1  high in any non-IDLE state
o_done  out  1  one-cycle pulse at normal completion

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low on i_rst_n: on a rising edge with i_rst_n=0, state=IDLE, index=0, timer=0, o_led=0, o_busy=0, o_done=0. Reset mid-playback returns to IDLE without asserting o_done.
- States: IDLE, GAP, SHOW, DONE. All outputs registered.
- IDLE: i_start=1 with 1<=i_len<=MAX_LEN -> latch length, index=0, timer=OFF_TICKS-1, go to GAP. An out-of-range i_len (0 or >MAX_LEN) is ignored and the block stays in IDLE.
- GAP: o_led=0, lasting exactly OFF_TICKS cycles. On the timer reaching 0, capture i_pat_data into the symbol register, set timer=on_time-1, go to SHOW.
- SHOW: o_led = 1 << symbol (00->0001, 01->0010, 10->0100, 11->1000), lasting exactly on_time cycles. On the timer reaching 0: if index==len-1 go to DONE, else index+1, timer=OFF_TICKS-1, go to GAP.
- DONE: o_led=0, o_done=1 for this one cycle, then go to IDLE.
- o_pat_addr always equals index. Index changes only on GAP entry, so the read data is stable by the end of GAP.
- Total busy time = len*(OFF_TICKS+on_time)+1 cycles. o_busy rises the cycle after i_start is accepted.
- i_start outside IDLE is ignored (no restart, no queueing).
- i_abort=1 in GAP/SHOW/DONE -> IDLE next cycle, o_led=0, o_done not asserted (a pending DONE pulse is suppressed). In IDLE, i_abort has priority: i_start in the same cycle is ignored.
- Timer is a down-counter sized to $clog2(max(ON_TICKS,OFF_TICKS)+1). No wrap; it is only loaded on state entry.

Optional Feature:
SEQ_SPEEDUP_EN: when defined, on_time is computed at start as max(MIN_TICKS, ON_TICKS-(len-1)*SPEED_STEP), using saturating arithmetic with no underflow, and is held for the whole playback. When undefined, on_time=ON_TICKS, and SPEED_STEP and MIN_TICKS are unused.

Test Plan:
Parameters for all scenarios: ON_TICKS=4, OFF_TICKS=3, MAX_LEN=8; memory model with 1-cycle read latency.
1. Reset: i_rst_n=0 for 2 cycles during playback -> o_led=0, o_busy=0, o_done=0, o_pat_addr=0; no done pulse.
2. Basic playback: memory {2,0,3}, start with len=3 -> o_led sequence 0000x3, 0100x4, 0000x3, 0001x4, 0000x3, 1000x4; then o_done=1 for 1 cycle. o_busy is high for 22 cycles.
3. Invalid length: start with len=0, then with len=9 -> o_busy stays 0, no o_done, o_pat_addr stays 0.
4. Abort: abort on the 2nd cycle of the 2nd SHOW -> next cycle o_led=0, o_busy=0, no o_done. A new start with len=1 then shows memory[0] after 3 dark cycles.
5. Start handling: i_start pulsed mid-playback -> no effect on timing. i_start+i_abort together in IDLE -> o_busy stays 0.
6. Speedup (SEQ_SPEEDUP_EN, SPEED_STEP=1, MIN_TICKS=2): len=2 -> each SHOW lasts 3 cycles. len=5 -> each SHOW lasts 2 cycles (floor applied).

Source files
------------

// File: rtl/pattern_sequencer.sv
// Pattern playback controller: walks a stored 2-bit symbol sequence and flashes one-hot LEDs
// with dark gaps. Optional on-time speedup with sequence length is enabled by SEQ_SPEEDUP_EN.
//
// state | meaning
// IDLE  | waiting for a valid start request
// GAP   | LEDs dark for OFF_TICKS cycles, pattern memory read settles
// SHOW  | LED for the captured symbol lit for on_time cycles
// DONE  | one-cycle completion pulse, then back to IDLE
module pattern_sequencer #(
    parameter int ON_TICKS   = 12500000,
    parameter int OFF_TICKS  = 12500000,
    parameter int MAX_LEN    = 16,
    parameter int SPEED_STEP = 500000,
    parameter int MIN_TICKS  = 2500000,
    localparam int ADDR_W    = $clog2(MAX_LEN)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_pat_addr,
    input  logic [1:0]        i_pat_data,
    output logic [3:0]        o_led,
    output logic              o_busy,
    output logic              o_done
);

    localparam int LEN_W   = ADDR_W + 1;
    localparam int MAX_T   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TIMER_W = $clog2(MAX_T + 1);

    if (ON_TICKS < 1 || OFF_TICKS < 2 || MAX_LEN < 2 || SPEED_STEP < 0 || MIN_TICKS < 1
        || MIN_TICKS > ON_TICKS) begin : g_bad_cfg
        $error("pattern_sequencer: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_SHOW,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  index, index_nxt;
    logic [LEN_W-1:0]   len_q, len_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [1:0]         symbol, symbol_nxt;
    logic [3:0]         led_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [TIMER_W-1:0] on_time;
    logic               len_ok;
    logic               start_ok;
    logic               last_step;

    assign len_ok    = (i_len != '0) && (i_len <= LEN_W'(MAX_LEN));
    assign start_ok  = i_start && !i_abort && len_ok;
    assign last_step = ({1'b0, index} == (len_q - LEN_W'(1)));

`ifdef SEQ_SPEEDUP_EN
    logic [LEN_W-1:0]   extra_steps;
    logic [63:0]        reduction;
    logic [TIMER_W-1:0] on_time_start;
    logic [TIMER_W-1:0] on_time_q;

    // Saturating max(MIN_TICKS, ON_TICKS - (len-1)*SPEED_STEP), frozen for the whole playback
    always_comb begin
        extra_steps = i_len - LEN_W'(1);
        reduction   = 64'(extra_steps) * 64'(SPEED_STEP);
        if (reduction + 64'(MIN_TICKS) >= 64'(ON_TICKS)) begin
            on_time_start = TIMER_W'(MIN_TICKS);
        end else begin
            on_time_start = TIMER_W'(64'(ON_TICKS) - reduction);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            on_time_q <= TIMER_W'(ON_TICKS);
        end else if (state == S_IDLE && start_ok) begin
            on_time_q <= on_time_start;
        end
    end

    assign on_time = on_time_q;
`else
    assign on_time = TIMER_W'(ON_TICKS);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            index  <= '0;
            len_q  <= '0;
            timer  <= '0;
            symbol <= '0;
            o_led  <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_nxt;
            index  <= index_nxt;
            len_q  <= len_nxt;
            timer  <= timer_nxt;
            symbol <= symbol_nxt;
            o_led  <= led_nxt;
            o_busy <= busy_nxt;
            o_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        index_nxt  = index;
        len_nxt    = len_q;
        timer_nxt  = timer;
        symbol_nxt = symbol;
        led_nxt    = '0;
        busy_nxt   = 1'b1;
        done_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                if (start_ok) begin
                    state_nxt = S_GAP;
                    len_nxt   = i_len;
                    index_nxt = '0;
                    timer_nxt = TIMER_W'(OFF_TICKS - 1);
                    busy_nxt  = 1'b1;
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    state_nxt  = S_SHOW;
                    symbol_nxt = i_pat_data;
                    timer_nxt  = on_time - TIMER_W'(1);
                    led_nxt    = 4'b0001 << i_pat_data;
                end else begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            S_SHOW: begin
                led_nxt = 4'b0001 << symbol;
                if (timer == '0) begin
                    led_nxt = '0;
                    if (last_step) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_GAP;
                        index_nxt = index + ADDR_W'(1);
                        timer_nxt = TIMER_W'(OFF_TICKS - 1);
                    end
                end else begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                index_nxt = '0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        // Abort wins over every transition, including the one into DONE
        if (i_abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            index_nxt = '0;
            timer_nxt = '0;
            led_nxt   = '0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    assign o_pat_addr = index;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: expected per-cycle {led, busy, done, addr} queued at stimulus time,
// popped and compared on every falling edge.
module tb_pattern_sequencer;

    localparam int ON_T  = 4;
    localparam int OFF_T = 3;
    localparam int MAXL  = 8;
    localparam int AW    = 3;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic [AW:0]   i_len;
    logic          i_abort;
    logic [AW-1:0] o_pat_addr;
    logic [1:0]    i_pat_data;
    logic [3:0]    o_led;
    logic          o_busy;
    logic          o_done;

    logic [1:0] mem [MAXL];

    typedef logic [8:0] exp_t;
    exp_t  exp_q [$];
    int    checks = 0;
    int    passed = 0;
    int    fails  = 0;
    string tag    = "init";

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) i_pat_data <= mem[o_pat_addr];

    pattern_sequencer #(
        .ON_TICKS  (ON_T),
        .OFF_TICKS (OFF_T),
        .MAX_LEN   (MAXL),
        .SPEED_STEP(1),
        .MIN_TICKS (2)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_len     (i_len),
        .i_abort   (i_abort),
        .o_pat_addr(o_pat_addr),
        .i_pat_data(i_pat_data),
        .o_led     (o_led),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    // Hand-derived on-times: speedup build uses max(2, 4-(len-1))
    function automatic int exp_on(input int len);
`ifdef SEQ_SPEEDUP_EN
        case (len)
            1:       return 4;
            2:       return 3;
            default: return 2;
        endcase
`else
        return ON_T;
`endif
    endfunction

    function automatic exp_t pk(input logic [3:0] led, input logic busy, input logic done,
                                input logic [2:0] addr);
        return {led, busy, done, addr};
    endfunction

    task automatic push_gap(input int step);
        for (int c = 0; c < OFF_T; c++) exp_q.push_back(pk(4'b0000, 1'b1, 1'b0, 3'(step)));
    endtask

    task automatic push_show(input int step, input int cycles);
        logic [3:0] one;
        one = 4'b0001;
        for (int c = 0; c < cycles; c++) exp_q.push_back(pk(one << mem[step], 1'b1, 1'b0, 3'(step)));
    endtask

    task automatic push_play(input int len, input int on);
        for (int s = 0; s < len; s++) begin
            push_gap(s);
            push_show(s, on);
        end
        exp_q.push_back(pk(4'b0000, 1'b1, 1'b1, 3'(len - 1)));
        exp_q.push_back(pk(4'b0000, 1'b0, 1'b0, 3'd0));
    endtask

    task automatic push_idle(input int n);
        for (int c = 0; c < n; c++) exp_q.push_back(pk(4'b0000, 1'b0, 1'b0, 3'd0));
    endtask

    task automatic kick(input int len, input logic abort_too);
        i_start = 1'b1;
        i_len   = 4'(len);
        i_abort = abort_too;
    endtask

    task automatic drain(input int n);
        exp_t e;
        exp_t obs;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            i_abort = 1'b0;
            obs = {o_led, o_busy, o_done, o_pat_addr};
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL %s: observed %h with no expected entry queued", tag, obs);
            end else begin
                e = exp_q.pop_front();
                assert (obs === e) passed++;
                else begin
                    fails++;
                    $error("FAIL %s: observed led/busy/done/addr %h expected %h", tag, obs, e);
                end
            end
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_len   = '0;
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
        mem[4] = 2'd2; mem[5] = 2'd1; mem[6] = 2'd0; mem[7] = 2'd3;

        tag = "reset";
        push_idle(3);
        drain(3);
        i_rst_n = 1'b1;

        tag = "basic";
        push_play(3, exp_on(3));
        kick(3, 1'b0);
        drain(3 * (OFF_T + exp_on(3)) + 2);

        tag = "bad_len0";
        push_idle(3);
        kick(0, 1'b0);
        drain(3);

        tag = "bad_len9";
        push_idle(3);
        kick(9, 1'b0);
        drain(3);

        tag = "abort";
        push_gap(0);
        push_show(0, exp_on(3));
        push_gap(1);
        push_show(1, 2);
        kick(3, 1'b0);
        drain(OFF_T + exp_on(3) + OFF_T + 2);
        i_abort = 1'b1;
        push_idle(2);
        drain(2);

        tag = "restart";
        push_play(1, exp_on(1));
        kick(1, 1'b0);
        drain(OFF_T + exp_on(1) + 2);

        tag = "start_mid";
        push_play(2, exp_on(2));
        kick(2, 1'b0);
        drain(5);
        i_start = 1'b1;
        i_len   = 4'd1;
        drain(2 * (OFF_T + exp_on(2)) + 2 - 5);

        tag = "start_abort";
        push_idle(3);
        kick(4, 1'b1);
        drain(3);

        tag = "reset_mid";
        push_gap(0);
        push_show(0, 2);
        kick(3, 1'b0);
        drain(OFF_T + 2);
        i_rst_n = 1'b0;
        push_idle(2);
        drain(2);
        i_rst_n = 1'b1;
        push_idle(3);
        drain(3);

`ifdef SEQ_SPEEDUP_EN
        tag = "speed_len2";
        push_play(2, 3);
        kick(2, 1'b0);
        drain(2 * (OFF_T + 3) + 2);

        tag = "speed_len5";
        push_play(5, 2);
        kick(5, 1'b0);
        drain(5 * (OFF_T + 2) + 2);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
